// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line filter.
package ps2_pkg;

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE, FAIL} state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_START_TO = 2'b01,
    ERR_FRAME_TO = 2'b10,
    ERR_NACK     = 2'b11
  } err_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake plus open-drain PS/2 line controls for the host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;
  logic       busy;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    input  tx_ready, tx_done, tx_err, err_code, busy, ps2_clk_oe, ps2_dat_oe
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    output tx_ready, tx_done, tx_err, err_code, busy, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_host_tx_line_filter.sv
// 2-FF synchronizers for PS/2 clock and data, plus a shift-register debouncer on the clock.
module ps2_line_filter #(
  parameter int FILTER_LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_raw_i,
  input  logic dat_raw_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o,
  output logic dat_sync_o
);

  logic [1:0]            clk_sync_q, dat_sync_q;
  logic [FILTER_LEN-1:0] hist_q;
  logic                  level_q;
  logic                  all_one, all_zero;

  assign all_one  = &hist_q;
  assign all_zero = ~|hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      hist_q     <= '1;
      level_q    <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], clk_raw_i};
      dat_sync_q <= {dat_sync_q[0], dat_raw_i};
      hist_q     <= {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
      if (all_one)       level_q <= 1'b1;
      else if (all_zero) level_q <= 1'b0;
    end
  end

  // Edge pulses fire in the cycle the history settles, one cycle ahead of level_o.
  assign level_o    = level_q;
  assign fall_o     = level_q & all_zero;
  assign rise_o     = ~level_q & all_one;
  assign dat_sync_o = dat_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device clock, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 16,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_SETUP    = 50,
  parameter int START_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT  = 100000
) (
  input  logic          c50,
  input  logic          reset_all,
  ps2_host_tx_if.slave  bus
);

  localparam int CW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT, FRAME_TIMEOUT)) + 1;
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_AT   = CW'(INHIBIT_CYCLES - START_SETUP - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   frame_q, frame_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            par_q, par_d;
  logic            clk_oe_q, clk_oe_d;
  logic            dat_oe_q, dat_oe_d;
  logic            done_q, done_d;
  err_e            code_q, code_d;

  logic clk_level, clk_fall, dat_sync;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk        (c50),
    .rst_n      (reset_all),
    .clk_raw_i  (bus.ps2_clk_in),
    .dat_raw_i  (bus.ps2_dat_in),
    .level_o    (clk_level),
    .fall_o     (clk_fall),
    .rise_o     (),
    .dat_sync_o (dat_sync)
  );

  always_ff @(posedge c50 or negedge reset_all) begin
    if (!reset_all) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      frame_q  <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      par_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      par_q    <= par_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      done_q   <= done_d;
      code_q   <= code_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frame_d  = frame_q;
    bit_d    = bit_q;
    data_d   = data_q;
    par_d    = par_q;
    clk_oe_d = 1'b0;
    dat_oe_d = dat_oe_q;
    done_d   = 1'b0;
    code_d   = code_q;
    unique case (state_q)
      IDLE: begin
        dat_oe_d = 1'b0;
        if (bus.tx_valid) begin
          data_d   = bus.tx_data;
          par_d    = ~^bus.tx_data;
          code_d   = ERR_NONE;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q >= SETUP_AT) dat_oe_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (clk_fall) begin
          dat_oe_d = ~data_q[0];
          bit_d    = 4'd1;
          frame_d  = '0;
          state_d  = SHIFT;
        end else if (cnt_q == START_LAST) begin
          dat_oe_d = 1'b0;
          code_d   = ERR_START_TO;
          state_d  = FAIL;
        end
      end
      SHIFT: begin
        frame_d = frame_q + CW'(1);
        if (frame_q == FRAME_LAST) begin
          dat_oe_d = 1'b0;
          code_d   = ERR_FRAME_TO;
          state_d  = FAIL;
        end else if (clk_fall) begin
          // bit_q counts falls already seen; fall 11 is the device ACK slot.
          if (bit_q == 4'd10) begin
            bit_d    = 4'd11;
            dat_oe_d = 1'b0;
            if (dat_sync) begin
              code_d  = ERR_NACK;
              state_d = FAIL;
            end else begin
              state_d = WAIT_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            if (bit_q <= 4'd7)      dat_oe_d = ~data_q[bit_q[2:0]];
            else if (bit_q == 4'd8) dat_oe_d = ~par_q;
            else                    dat_oe_d = 1'b0;
          end
        end
      end
      WAIT_IDLE: begin
        dat_oe_d = 1'b0;
        frame_d  = frame_q + CW'(1);
        if (frame_q == FRAME_LAST) begin
          code_d  = ERR_FRAME_TO;
          state_d = FAIL;
        end else if (clk_level && dat_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      FAIL: begin
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        dat_oe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  assign bus.tx_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.tx_done    = done_q;
  assign bus.tx_err     = (state_q == FAIL);
  assign bus.err_code   = code_q;
  assign bus.ps2_clk_oe = clk_oe_q;
  assign bus.ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench: a behavioural PS/2 device clocks frames out of the host transmitter.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int FL = 16, INH = 200, SETUP = 20, START_TO = 3000, FRAME_TO = 2000, HALF = 40;

  logic c50 = 1'b0;
  logic reset_all = 1'b1;
  logic dev_clk = 1'b1, dev_dat = 1'b1;
  int   cyc = 0, n_pass = 0, n_tot = 0;
  int   n_done = 0, n_err = 0, n_req = 0;
  int   t_rise, t_dat, t_fall, t_fall1;
  int   b_done, b_err, b_req;
  bit   both_seen = 1'b0, idle_oe = 1'b0;
  logic prev_clk_oe = 1'b0;
  logic [9:0] seen;

  ps2_host_tx_if bus();
  assign bus.ps2_clk_in = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_dat_in = dev_dat & ~bus.ps2_dat_oe;

  ps2_host_tx #(
    .FILTER_LEN(FL), .INHIBIT_CYCLES(INH), .START_SETUP(SETUP),
    .START_TIMEOUT(START_TO), .FRAME_TIMEOUT(FRAME_TO)
  ) dut (
    .c50(c50), .reset_all(reset_all), .bus(bus)
  );

  always #10 c50 = ~c50;
  always @(posedge c50) cyc++;

  always @(negedge c50) begin
    if (bus.tx_done) n_done++;
    if (bus.tx_err) n_err++;
    if (bus.tx_done && bus.tx_err) both_seen = 1'b1;
    if (bus.tx_ready && (bus.ps2_clk_oe || bus.ps2_dat_oe)) idle_oe = 1'b1;
    if (bus.ps2_clk_oe && !prev_clk_oe) n_req++;
    prev_clk_oe = bus.ps2_clk_oe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge c50);
  endtask

  // Accept a byte, then time the inhibit window and the start-bit setup.
  task automatic send(input logic [7:0] b, input bit inject);
    bus.tx_data = b; bus.tx_valid = 1'b1;
    @(negedge c50);
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    chk("accept_lat_clk_oe", bus.ps2_clk_oe, 1);
    chk("accept_busy", bus.busy, 1);
    t_rise = cyc; t_dat = -1; t_fall = -1;
    for (int i = 0; i < INH + 50; i++) begin
      if (inject && i == 10) begin bus.tx_data = 8'h55; bus.tx_valid = 1'b1; end
      if (inject && i == 11) begin bus.tx_data = 8'h00; bus.tx_valid = 1'b0; end
      @(negedge c50);
      if (bus.ps2_dat_oe && t_dat < 0) t_dat = cyc;
      if (!bus.ps2_clk_oe) begin t_fall = cyc; break; end
    end
    chk("inhibit_len", t_fall - t_rise, INH);
    chk("start_setup", t_fall - t_dat, SETUP);
    chk("req_start_bit", bus.ps2_dat_oe, 1);
  endtask

  // Device clocks nfalls falling edges; line data is sampled at the end of each low phase.
  task automatic device(input int nfalls, input bit ack);
    seen = '0;
    cycles(2*HALF);
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11 && ack) dev_dat = 1'b0;
      cycles(HALF);
      dev_clk = 1'b0;
      if (i == 1) t_fall1 = cyc;
      cycles(HALF);
      if (i <= 10) seen[i-1] = bus.ps2_dat_in;
      dev_clk = 1'b1;
    end
    if (nfalls == 11) begin cycles(HALF); dev_dat = 1'b1; end
  endtask

  task automatic wait_pulse(input int budget, input string tag);
    int k = 0;
    while (!(bus.tx_done || bus.tx_err) && k < budget) begin @(negedge c50); k++; end
    chk({tag, "_in_time"}, (k < budget), 1);
  endtask

  initial begin
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
    #5 reset_all = 1'b0;
    cycles(3);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    chk("rst_pulses", {bus.tx_done, bus.tx_err}, 0);
    chk("rst_code", bus.err_code, ERR_NONE);
    @(negedge c50) reset_all = 1'b1;
    cycles(40);

    // 0xED: bits 1,0,1,1,0,1,1,1 then parity 1, stop 1.
    b_done = n_done; b_err = n_err;
    send(CMD_SET_LED, 1'b0);
    device(11, 1'b1);
    wait_pulse(500, "ed_done");
    chk("ed_done", bus.tx_done, 1);
    chk("ed_code", bus.err_code, ERR_NONE);
    chk("ed_busy", bus.busy, 0);
    chk("ed_bits", seen, 10'h3ED);
    cycles(1);
    chk("ed_done_once", bus.tx_done, 0);
    cycles(5);
    chk("ed_done_cnt", n_done - b_done, 1);
    chk("ed_no_err", n_err - b_err, 0);

    // 0xF4: parity 0.
    b_done = n_done;
    send(CMD_ENABLE, 1'b0);
    device(11, 1'b1);
    wait_pulse(500, "f4_done");
    chk("f4_done", bus.tx_done, 1);
    chk("f4_bits", seen, 10'h2F4);
    cycles(5);

    // No device: start timeout measured from clock release.
    send(CMD_RESET, 1'b0);
    wait_pulse(START_TO + 100, "sto");
    chk("sto_err", bus.tx_err, 1);
    chk("sto_time", cyc - t_fall, START_TO);
    chk("sto_code", bus.err_code, ERR_START_TO);
    cycles(1);
    chk("sto_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    chk("sto_ready", bus.tx_ready, 1);
    cycles(5);

    // Data left high at fall 11: NACK.
    b_done = n_done; b_err = n_err;
    send(CMD_ENABLE, 1'b0);
    device(11, 1'b0);
    cycles(5);
    chk("nack_err_cnt", n_err - b_err, 1);
    chk("nack_done_cnt", n_done - b_done, 0);
    chk("nack_code", bus.err_code, ERR_NACK);
    chk("nack_bits", seen, 10'h2F4);

    // Device stalls after fall 5: frame timeout; the DUT sees fall 1 FL+3 cycles late.
    send(CMD_SET_LED, 1'b0);
    device(5, 1'b0);
    wait_pulse(FRAME_TO + 200, "fto");
    chk("fto_err", bus.tx_err, 1);
    chk("fto_time", cyc - t_fall1, FRAME_TO + FL + 3);
    chk("fto_code", bus.err_code, ERR_FRAME_TO);
    cycles(5);

    // Reset mid-SHIFT releases both lines with no clock edge.
    send(8'h00, 1'b0);
    device(4, 1'b0);
    chk("rst_pre_dat_oe", bus.ps2_dat_oe, 1);
    reset_all = 1'b0;
    #1;
    chk("rst_mid_oe", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    chk("rst_mid_busy", bus.busy, 0);
    @(negedge c50) reset_all = 1'b1;
    cycles(3);
    chk("rst_after_ready", bus.tx_ready, 1);
    chk("rst_after_code", bus.err_code, ERR_NONE);

    // tx_valid while busy must not start a second frame.
    b_done = n_done; b_req = n_req;
    send(CMD_ENABLE, 1'b1);
    device(11, 1'b1);
    wait_pulse(500, "inj_done");
    chk("inj_done", bus.tx_done, 1);
    chk("inj_bits", seen, 10'h2F4);
    cycles(3*INH);
    chk("inj_one_frame", n_req - b_req, 1);
    chk("inj_done_cnt", n_done - b_done, 1);
    chk("inj_ready", bus.tx_ready, 1);

    chk("done_err_excl", both_seen, 0);
    chk("idle_oe", idle_oe, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; sends one command byte per request to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Sits beside the keyboard receiver on the same PS2_CLK/PS2_DAT pair and drives both lines open-drain through output-enable signals.
- Runs the request-to-send sequence, shifts the byte out on device-generated clock edges, checks the device ACK and reports done or error.
- Asserts `busy` so the receiver ignores line activity during a transmit.

Parameters:
- FILTER_LEN, 16: number of consecutive equal c50 samples needed to change the filtered PS/2 clock level.
- INHIBIT_CYCLES, 5000: cycles `ps2_clk_oe` is held low (100 us at 50 MHz).
- START_SETUP, 50: final cycles of the inhibit window during which `ps2_dat_oe` is also asserted.
- START_TIMEOUT, 750000: maximum cycles from clock release to the first device falling edge (15 ms).
- FRAME_TIMEOUT, 100000: maximum cycles from the first falling edge to ACK (2 ms).

Ports:
- c50, input, 1: system clock, 50 MHz.
- reset_all, input, 1: asynchronous active-low reset.
- tx_data, input, 8: command byte.
- tx_valid, input, 1: transmit request; accepted only while tx_ready=1.
- tx_ready, output, 1: high only in IDLE.
- tx_done, output, 1: one-cycle pulse on successful ACK and bus return to idle.
- tx_err, output, 1: one-cycle pulse on failure.
- err_code, output, 2: 01 start timeout, 10 frame timeout, 11 NACK; held until the next accept.
- busy, output, 1: high in every state except IDLE.
- ps2_clk_in, input, 1: raw PS/2 clock line level.
- ps2_dat_in, input, 1: raw PS/2 data line level.
- ps2_clk_oe, output, 1: 1 pulls the clock line low, 0 releases it.
- ps2_dat_oe, output, 1: 1 pulls the data line low, 0 releases it.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; ps2_clk_oe=0, ps2_dat_oe=0; tx_done=0, tx_err=0, err_code=00.
  - Counters cleared; filter history all ones.
  - A reset mid-frame releases both lines in the same instant.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer.
  - Clock filter: the filtered clock goes to 1 after FILTER_LEN consecutive ones and to 0 after FILTER_LEN consecutive zeros; otherwise it holds.
  - fall = filtered clock goes from 1 to 0.
  - Data is sampled from the synchronized value, not filtered.
- Accept: tx_valid && tx_ready latches tx_data, computes odd parity (parity = ~^tx_data), clears err_code and enters INHIBIT. tx_valid is ignored in all other states.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - ps2_dat_oe=1 during the last START_SETUP of those cycles (start bit).
  - Then go to REQ.
- REQ:
  - ps2_clk_oe=0, ps2_dat_oe=1; timer counts START_TIMEOUT.
  - On fall: drive bit 0, bit counter=1, go to SHIFT.
  - On timeout: go to FAIL with code 01.
- SHIFT:
  - Data is updated only on fall. The line value is 0 → dat_oe=1; 1 → dat_oe=0.
  - Falls 1..8 drive tx_data[0..7], LSB first; fall 9 drives parity; fall 10 releases data (stop bit).
  - Fall 11 samples data: 0 → WAIT_IDLE; 1 → FAIL with code 11.
  - A frame timer started at fall 1 expiring before fall 11 → FAIL with code 10.
- WAIT_IDLE:
  - Both oe=0; wait until filtered clock=1 and synchronized data=1.
  - Then tx_done=1 for one cycle and go to IDLE.
  - The frame timer still applies (code 10).
- FAIL: both oe=0, tx_err=1 for one cycle, go to IDLE.
- tx_done and tx_err are never asserted in the same cycle. Neither oe is ever asserted in IDLE.
- Counter widths: $clog2 of the largest timeout parameter + 1. The bit counter is 4 bits and saturates at 11.
- Latency from accept to the first line change is 1 cycle (ps2_clk_oe rises).

Decomposition:
- Package ps2_pkg:
  - State enum {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE, FAIL}.
  - Error codes ERR_NONE, ERR_START_TO, ERR_FRAME_TO, ERR_NACK.
  - Command constants CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF, plus RSP_ACK=8'hFA.
- Sub-module ps2_line_filter, shared with the receiver:
  - Synchronizer plus FILTER_LEN shift-register debouncer.
  - Outputs: level, fall pulse, rise pulse.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz → line shows bits 1,0,1,1,0,1,1,1, parity 1, stop 1; model ACKs → tx_done pulses once, err_code=00, busy falls after the bus idles.
- Send 0xF4 → parity bit 0; ps2_clk_oe high for exactly 5000 cycles; ps2_dat_oe rises exactly 50 cycles before ps2_clk_oe falls.
- No device response → tx_err pulses 750000 cycles after clock release, err_code=01, both oe=0, tx_ready=1.
- Device leaves data high at fall 11 → tx_err, err_code=11.
- Device stops clocking after fall 5 → tx_err after 100000 cycles from fall 1, err_code=10.
- Reset during SHIFT → both oe drop with no clock edge; after reset release tx_ready=1, and a tx_valid pulse during busy in a later frame is ignored (one frame only).
